// File: rtl/retention_bank.sv
// retention_bank: PMU retention store that saves NUM_REGS words over valid/ready and streams them back in order.
// Define RET_PARITY_EN to store an even-parity bit per word and flag corrupted words on restore.
module retention_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int T_WAIT = 5,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = (T_WAIT > 0) ? $clog2(T_WAIT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic              abort,
  input  logic [DATA_W-1:0] save_data,
  input  logic              save_valid,
  output logic              save_ready,
  output logic [DATA_W-1:0] restore_data,
  output logic              restore_valid,
  input  logic              restore_ready,
  output logic [AW-1:0]     restore_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_valid,
  output logic              err
);
`ifdef RET_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  localparam logic [CW-1:0] TOP = CW'(T_WAIT);
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;
  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_cnt;
  logic [MW-1:0]     r_mem [NUM_REGS];
  logic              r_err;
  logic              r_done;
  logic              r_mem_valid;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [AW-1:0]     r_raddr;
  logic              w_window;
  logic              w_save_xfer;
  logic              w_rest_xfer;
  logic              w_load;
  logic              w_par_err;
  logic [MW-1:0]     w_entry;

  assign w_window = r_cnt == TOP;
  assign save_ready = r_state == SAVE && w_window;
  // abort beats any same-cycle handshake, so the word in flight is dropped
  assign w_save_xfer = save_ready && save_valid && !abort;
  assign w_rest_xfer = r_state == RESTORE && r_rvalid && restore_ready && !abort;
  assign w_load = r_state == RESTORE && !r_rvalid && w_window && !abort;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign mem_valid = r_mem_valid;
  assign restore_valid = r_rvalid;
  assign restore_data = r_rdata;
  assign restore_addr = r_raddr;
  assign err = r_err | w_par_err;

`ifdef RET_PARITY_EN
  logic r_rpar;
  assign w_entry = {^save_data, save_data};
  assign w_par_err = w_rest_xfer && ((^r_rdata) != r_rpar);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rpar <= 1'b0;
    else if (w_load) r_rpar <= r_mem[r_addr][DATA_W];
`else
  assign w_entry = save_data;
  assign w_par_err = 1'b0;
`endif

  always_ff @(posedge clk)
    if (w_save_xfer) r_mem[r_addr] <= w_entry;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_done <= 1'b0;
      r_mem_valid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata <= '0;
      r_raddr <= '0;
    end else begin
      r_done <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr <= '0;
          r_cnt <= '0;
          if (save_req) begin
            r_state <= SAVE;
            r_mem_valid <= 1'b0;
          end else if (restore_req && r_mem_valid) r_state <= RESTORE;
          else if (restore_req) r_err <= 1'b1;
        end
        SAVE:
          if (abort) r_state <= IDLE;
          else if (w_save_xfer) begin
            r_cnt <= '0;
            r_addr <= r_addr + AW'(1);
            if (r_addr == LAST) begin
              r_state <= IDLE;
              r_done <= 1'b1;
              r_mem_valid <= 1'b1;
            end
          end else if (!w_window) r_cnt <= r_cnt + CW'(1);
        RESTORE:
          if (abort) begin
            r_state <= IDLE;
            r_rvalid <= 1'b0;
          end else if (w_rest_xfer) begin
            r_rvalid <= 1'b0;
            r_cnt <= '0;
            r_addr <= r_addr + AW'(1);
            if (r_addr == LAST) begin
              r_state <= IDLE;
              r_done <= 1'b1;
            end
          end else if (w_load) begin
            r_rvalid <= 1'b1;
            r_rdata <= r_mem[r_addr][DATA_W-1:0];
            r_raddr <= r_addr;
          end else if (!w_window) r_cnt <= r_cnt + CW'(1);
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_retention_bank.sv
// tb_retention_bank: randomized save/restore sequences checked against a cycle-level reference model.
module tb_retention_bank;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int T_WAIT = 5;
  localparam int AW = 4;
  logic clk = 0;
  logic rst = 1;
  logic save_req = 0;
  logic restore_req = 0;
  logic abort = 0;
  logic save_valid = 0;
  logic restore_ready = 0;
  logic [DATA_W-1:0] save_data = '0;
  logic save_ready, restore_valid, busy, done, mem_valid, err;
  logic [DATA_W-1:0] restore_data;
  logic [AW-1:0] restore_addr;
  logic [DATA_W-1:0] ref_mem [NUM_REGS];
  int corrupt_k = -1;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  retention_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .T_WAIT(T_WAIT)) dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req), .abort(abort),
    .save_data(save_data), .save_valid(save_valid), .save_ready(save_ready),
    .restore_data(restore_data), .restore_valid(restore_valid), .restore_ready(restore_ready),
    .restore_addr(restore_addr), .busy(busy), .done(done), .mem_valid(mem_valid), .err(err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty_restore;
    restore_req = 1;
    step;
    restore_req = 0;
    n_total++;
    if ({err, busy, mem_valid} !== 3'b100) $display("FAIL empty_restore: err/busy/mem_valid got %b expected 100", {err, busy, mem_valid});
    else n_pass++;
    step;
    n_total++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL empty_restore_pulse: err/busy got %b%b expected 00", err, busy);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1;
    step;
    step;
    n_total++;
    if ({save_ready, restore_valid, busy, done, mem_valid, err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {save_ready, restore_valid, busy, done, mem_valid, err});
    else n_pass++;
    n_total++;
    if (restore_data !== '0 || restore_addr !== '0) $display("FAIL reset_data: got %h/%0d expected 0/0", restore_data, restore_addr);
    else n_pass++;
    rst = 0;
    step;
    test_empty_restore;
  endtask

  task automatic run_save(input bit pat, input bit rnd, input int abort_k, input bit both);
    int k = 0;
    int since = 0;
    int cyc = 0;
    bit exp_rdy;
    bit aborted = 0;
    save_req = 1;
    restore_req = both;
    step;
    save_req = 0;
    restore_req = 0;
    n_total++;
    if (busy !== 1'b1 || mem_valid !== 1'b0) $display("FAIL save_entry: busy/mem_valid got %b%b expected 10", busy, mem_valid);
    else n_pass++;
    while (k < NUM_REGS && !aborted && cyc < 4000) begin
      exp_rdy = since == T_WAIT;
      n_total++;
      if (save_ready !== exp_rdy || done !== 1'b0 || restore_valid !== 1'b0)
        $display("FAIL save_window k=%0d: ready/done/rvalid got %b%b%b expected %b00", k, save_ready, done, restore_valid, exp_rdy);
      else n_pass++;
      save_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      save_data = pat ? 32'hA000_0000 + k : $urandom;
      abort = (k == abort_k) && exp_rdy;
      step;
      cyc++;
      if (abort) aborted = 1;
      else if (save_valid && exp_rdy) begin
        ref_mem[k] = save_data;
        k++;
        since = 0;
      end else if (since < T_WAIT) since++;
    end
    abort = 0;
    save_valid = 0;
    if (cyc >= 4000) begin
      n_total++;
      $display("FAIL save_timeout: saved %0d words expected %0d", k, NUM_REGS);
    end
    if (aborted) begin
      n_total++;
      if ({busy, save_ready, done, mem_valid} !== 4'b0) $display("FAIL save_abort: busy/ready/done/mem_valid got %b expected 0000", {busy, save_ready, done, mem_valid});
      else n_pass++;
    end else begin
      n_total++;
      if ({done, busy, mem_valid} !== 3'b101) $display("FAIL save_done: done/busy/mem_valid got %b expected 101", {done, busy, mem_valid});
      else n_pass++;
      step;
      n_total++;
      if (done !== 1'b0) $display("FAIL save_done_pulse: done got %b expected 0", done);
      else n_pass++;
    end
  endtask

  task automatic run_restore(input bit rnd, input int stall_k, input int stall_n, input int abort_k);
    int k = 0;
    int since = 0;
    int cyc = 0;
    int stalled = 0;
    bit exp_v = 0;
    bit rdy;
    bit aborted = 0;
    restore_req = 1;
    step;
    restore_req = 0;
    n_total++;
    if (busy !== 1'b1 || restore_valid !== 1'b0) $display("FAIL restore_entry: busy/rvalid got %b%b expected 10", busy, restore_valid);
    else n_pass++;
    while (k < NUM_REGS && !aborted && cyc < 4000) begin
      n_total++;
      if (restore_valid !== exp_v || done !== 1'b0) $display("FAIL restore_valid k=%0d: rvalid/done got %b%b expected %b0", k, restore_valid, done, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_total++;
        if (restore_data !== ref_mem[k] || restore_addr !== AW'(k))
          $display("FAIL restore_beat: got %h@%0d expected %h@%0d", restore_data, restore_addr, ref_mem[k], k);
        else n_pass++;
      end
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else if (k == stall_k && stalled < stall_n && exp_v) begin
        rdy = 0;
        stalled++;
      end else rdy = 1;
      restore_ready = rdy;
      abort = exp_v && k == abort_k;
      #1;
      n_total++;
      if (err !== (exp_v && rdy && !abort && k == corrupt_k)) $display("FAIL restore_err k=%0d: err got %b", k, err);
      else n_pass++;
      step;
      cyc++;
      if (abort) aborted = 1;
      else if (exp_v && rdy) begin
        k++;
        exp_v = 0;
        since = 0;
      end else if (!exp_v) begin
        if (since == T_WAIT) exp_v = 1;
        else since++;
      end
    end
    abort = 0;
    restore_ready = 0;
    if (cyc >= 4000) begin
      n_total++;
      $display("FAIL restore_timeout: restored %0d words expected %0d", k, NUM_REGS);
    end
    n_total++;
    if ({done, busy, mem_valid, restore_valid} !== {!aborted, 3'b010})
      $display("FAIL restore_end: done/busy/mem_valid/rvalid got %b expected %b010", {done, busy, mem_valid, restore_valid}, !aborted);
    else n_pass++;
    step;
  endtask

  task automatic test_abort_idle;
    abort = 1;
    step;
    abort = 0;
    n_total++;
    if ({busy, done, err, mem_valid} !== 4'b0001) $display("FAIL abort_idle: busy/done/err/mem_valid got %b expected 0001", {busy, done, err, mem_valid});
    else n_pass++;
  endtask

  task automatic test_abort_save;
    run_save(1, 0, 7, 0);
    test_empty_restore;
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++) begin
      run_save(0, 1, -1, 0);
      run_restore(1, -1, 0, -1);
    end
  endtask

  task automatic test_abort_restore;
    run_restore(0, -1, 0, 9);
    run_restore(1, -1, 0, -1);
  endtask

`ifdef RET_PARITY_EN
  task automatic test_parity;
    dut.r_mem[3][0] = ~dut.r_mem[3][0];
    ref_mem[3][0] = ~ref_mem[3][0];
    corrupt_k = 3;
    run_restore(0, -1, 0, -1);
    corrupt_k = -1;
    run_save(0, 0, -1, 0);
  endtask
`endif

  task automatic test_reset_mid;
    restore_req = 1;
    step;
    restore_req = 0;
    step;
    step;
    rst = 1;
    #1;
    n_total++;
    if ({busy, mem_valid, restore_valid, save_ready, done} !== 5'b0)
      $display("FAIL reset_mid: busy/mem_valid/rvalid/ready/done got %b expected 00000", {busy, mem_valid, restore_valid, save_ready, done});
    else n_pass++;
    step;
    rst = 0;
    step;
    test_empty_restore;
  endtask

  initial begin
    test_reset;
    run_save(1, 0, -1, 0);
    run_restore(0, -1, 0, -1);
    run_restore(0, 4, 3, -1);
    test_abort_idle;
    test_abort_save;
    test_random;
    test_abort_restore;
    run_save(0, 0, -1, 1);
    run_restore(0, -1, 0, -1);
`ifdef RET_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
